// File: rtl/alu_operand_collector.sv
// Collects operand beats for one ALU operation, then issues one CE-qualified request.
// A partial request is issued, flagged by TIMEOUT_ERR, if an operand never arrives.
module alu_operand_collector #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       IN_INP_VALID,
  input  logic             IN_MODE,
  input  logic [3:0]       IN_CMD,
  input  logic [WIDTH-1:0] IN_OPA,
  input  logic [WIDTH-1:0] IN_OPB,
  input  logic             IN_CIN,
  output logic             ALU_CE,
  output logic             ALU_MODE,
  output logic [3:0]       ALU_CMD,
  output logic [WIDTH-1:0] ALU_OPA,
  output logic [WIDTH-1:0] ALU_OPB,
  output logic             ALU_CIN,
  output logic [1:0]       ALU_INP_VALID,
  output logic             TIMEOUT_ERR,
  output logic             BUSY
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               mode_reg;
  logic [3:0]         cmd_reg;
  logic               cin_reg;
  logic [1:0]         have_reg;
  logic [WIDTH-1:0]   opa_reg;
  logic [WIDTH-1:0]   opb_reg;

  logic               accept;
  logic               fresh;
  logic               abort;
  logic               mode_m;
  logic [3:0]         cmd_m;
  logic               cin_m;
  logic [1:0]         have_m;
  logic [WIDTH-1:0]   opa_m;
  logic [WIDTH-1:0]   opb_m;
  logic [1:0]         req_m;
  logic               complete;
  logic               timeout;

  function automatic logic [1:0] req_of(input logic mode, input logic [3:0] cmd);
    logic [1:0] r;
    r = 2'b00;
    if (mode) begin
      case (cmd)
        4'd4, 4'd5:                             r = 2'b10;
        4'd6, 4'd7:                             r = 2'b01;
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9,
        4'd10, 4'd11, 4'd12:                    r = 2'b11;
        default:                                r = 2'b00;
      endcase
    end else begin
      case (cmd)
        4'd6, 4'd8, 4'd9:                       r = 2'b10;
        4'd7, 4'd10, 4'd11:                     r = 2'b01;
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
        4'd12, 4'd13:                           r = 2'b11;
        default:                                r = 2'b00;
      endcase
    end
    return r;
  endfunction

  assign IN_READY = (state_reg != ISSUE);
  assign BUSY     = (state_reg != IDLE);

  // A beat starts a fresh collection in IDLE, or in WAIT when it names a different op.
  always_comb begin
    accept   = IN_VALID && IN_READY;
    fresh    = accept && ((state_reg == IDLE) ||
                          (IN_MODE != mode_reg) || (IN_CMD != cmd_reg));
    abort    = fresh && (state_reg == WAIT);
    mode_m   = fresh ? IN_MODE : mode_reg;
    cmd_m    = fresh ? IN_CMD  : cmd_reg;
    cin_m    = accept ? IN_CIN : cin_reg;
    have_m   = (fresh ? 2'b00 : have_reg) | (accept ? IN_INP_VALID : 2'b00);
    opa_m    = (accept && IN_INP_VALID[1]) ? IN_OPA : (fresh ? '0 : opa_reg);
    opb_m    = (accept && IN_INP_VALID[0]) ? IN_OPB : (fresh ? '0 : opb_reg);
    req_m    = req_of(mode_m, cmd_m);
    complete = accept && ((have_m & req_m) == req_m);
    // A completing beat on the last WAIT cycle wins over the timeout.
    timeout  = (state_reg == WAIT) && !fresh && !complete &&
               (cnt_reg == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      cmd_reg       <= 4'd0;
      cin_reg       <= 1'b0;
      have_reg      <= 2'b00;
      opa_reg       <= '0;
      opb_reg       <= '0;
      ALU_CE        <= 1'b0;
      ALU_MODE      <= 1'b0;
      ALU_CMD       <= 4'd0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      ALU_CIN       <= 1'b0;
      ALU_INP_VALID <= 2'b00;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      ALU_CE      <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      case (state_reg)
        IDLE, WAIT: begin
          if (complete) begin
            ALU_CE        <= 1'b1;
            TIMEOUT_ERR   <= abort;
            ALU_MODE      <= mode_m;
            ALU_CMD       <= cmd_m;
            ALU_CIN       <= cin_m;
            ALU_INP_VALID <= req_m;
            ALU_OPA       <= req_m[1] ? opa_m : '0;
            ALU_OPB       <= req_m[0] ? opb_m : '0;
            state_reg     <= ISSUE;
          end else if (timeout) begin
            ALU_CE        <= 1'b1;
            TIMEOUT_ERR   <= 1'b1;
            ALU_MODE      <= mode_m;
            ALU_CMD       <= cmd_m;
            ALU_CIN       <= cin_m;
            ALU_INP_VALID <= have_m;
            ALU_OPA       <= have_m[1] ? opa_m : '0;
            ALU_OPB       <= have_m[0] ? opb_m : '0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            have_reg      <= 2'b00;
            opa_reg       <= '0;
            opb_reg       <= '0;
          end else if (accept) begin
            TIMEOUT_ERR <= abort;
            mode_reg    <= mode_m;
            cmd_reg     <= cmd_m;
            cin_reg     <= cin_m;
            have_reg    <= have_m;
            opa_reg     <= opa_m;
            opb_reg     <= opb_m;
            cnt_reg     <= fresh ? '0 : cnt_reg + 1'b1;
            state_reg   <= WAIT;
          end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          have_reg  <= 2'b00;
          opa_reg   <= '0;
          opb_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: expected ALU events are queued as stimulus
// is driven and compared whenever the DUT raises ALU_CE or TIMEOUT_ERR.
module tb_alu_operand_collector;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [1:0]       IN_INP_VALID = 2'b00;
  logic             IN_MODE = 1'b0;
  logic [3:0]       IN_CMD = 4'd0;
  logic [WIDTH-1:0] IN_OPA = '0;
  logic [WIDTH-1:0] IN_OPB = '0;
  logic             IN_CIN = 1'b0;
  logic             ALU_CE;
  logic             ALU_MODE;
  logic [3:0]       ALU_CMD;
  logic [WIDTH-1:0] ALU_OPA;
  logic [WIDTH-1:0] ALU_OPB;
  logic             ALU_CIN;
  logic [1:0]       ALU_INP_VALID;
  logic             TIMEOUT_ERR;
  logic             BUSY;

  alu_operand_collector #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INP_VALID(IN_INP_VALID),
    .IN_MODE(IN_MODE), .IN_CMD(IN_CMD), .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CIN(IN_CIN),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD), .ALU_OPA(ALU_OPA),
    .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN), .ALU_INP_VALID(ALU_INP_VALID),
    .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ce;
    logic       terr;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic [1:0] iv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_ev(input logic ce, input logic terr, input logic mode,
                                    input logic [3:0] cmd, input logic [7:0] opa,
                                    input logic [7:0] opb, input logic cin,
                                    input logic [1:0] iv);
    exp_t e;
    e.ce = ce; e.terr = terr; e.mode = mode; e.cmd = cmd;
    e.opa = opa; e.opb = opb; e.cin = cin; e.iv = iv;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every cycle with ALU_CE or TIMEOUT_ERR must match the next queued event.
  always @(negedge CLK) begin
    if (!RST && (ALU_CE || TIMEOUT_ERR)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, ALU_CE, TIMEOUT_ERR}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ev_ce", ALU_CE, e.ce);
        check("ev_terr", TIMEOUT_ERR, e.terr);
        if (e.ce) begin
          check("ev_mode", ALU_MODE, e.mode);
          check("ev_cmd", ALU_CMD, e.cmd);
          check("ev_opa", ALU_OPA, e.opa);
          check("ev_opb", ALU_OPB, e.opb);
          check("ev_cin", ALU_CIN, e.cin);
          check("ev_iv", ALU_INP_VALID, e.iv);
        end
        $display("event ce=%0b terr=%0b mode=%0b cmd=%0d opa=%02h opb=%02h cin=%0b iv=%02b",
                 ALU_CE, TIMEOUT_ERR, ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN, ALU_INP_VALID);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                      input logic [7:0] a, input logic [7:0] b, input logic cin);
    int w;
    w = 0;
    while (!IN_READY && w < 8) begin
      @(posedge CLK); #1;
      w++;
    end
    if (!IN_READY) check("ready_wait", IN_READY, 1'b1);
    IN_VALID = 1'b1; IN_MODE = mode; IN_CMD = cmd; IN_INP_VALID = iv;
    IN_OPA = a; IN_OPB = b; IN_CIN = cin;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_INP_VALID = 2'b00;
    $display("beat mode=%0b cmd=%0d iv=%02b a=%02h b=%02h cin=%0b", mode, cmd, iv, a, b, cin);
  endtask

  initial begin
    int k;
    #3;
    check("rst_ce", ALU_CE, 1'b0);
    check("rst_opa", ALU_OPA, 8'h00);
    check("rst_iv", ALU_INP_VALID, 2'b00);
    check("rst_terr", TIMEOUT_ERR, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    @(negedge CLK); RST = 1'b0;
    idle(2);
    check("ready_after_rst", IN_READY, 1'b1);

    // 1: single complete beat, issue on the next cycle, then hold
    expect_ev(1, 0, 1, 4'd0, 8'h12, 8'h34, 1'b0, 2'b11);
    send(1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0);
    @(negedge CLK);
    check("t1_ce_latency", ALU_CE, 1'b1);
    check("t1_ready_issue", IN_READY, 1'b0);
    @(negedge CLK);
    check("t1_ce_one_cycle", ALU_CE, 1'b0);
    check("t1_hold_opa", ALU_OPA, 8'h12);
    idle(2);

    // 2: two beats with a gap
    send(1, 4'd0, 2'b10, 8'hFF, 8'h00, 1'b1);
    check("t2_busy", BUSY, 1'b1);
    idle(3);
    expect_ev(1, 0, 1, 4'd0, 8'hFF, 8'h01, 1'b0, 2'b11);
    send(1, 4'd0, 2'b01, 8'h00, 8'h01, 1'b0);
    idle(3);

    // 3: missing operand times out into a partial issue
    expect_ev(1, 1, 0, 4'd12, 8'h3C, 8'h00, 1'b1, 2'b10);
    send(0, 4'd12, 2'b10, 8'h3C, 8'h77, 1'b1);
    k = 0;
    while (k < 40) begin
      @(negedge CLK);
      k++;
      if (ALU_CE) break;
    end
    check("t3_timeout_latency", k, TIMEOUT + 1);
    idle(3);

    // 4: only OPB required, OPA masked to zero
    expect_ev(1, 0, 1, 4'd6, 8'h00, 8'h0F, 1'b1, 2'b01);
    send(1, 4'd6, 2'b11, 8'h55, 8'h0F, 1'b1);
    idle(3);

    // 5: different command aborts the wait and issues immediately
    send(1, 4'd1, 2'b10, 8'h11, 8'h00, 1'b0);
    idle(2);
    expect_ev(1, 1, 1, 4'd8, 8'hAA, 8'hBB, 1'b0, 2'b11);
    send(1, 4'd8, 2'b11, 8'hAA, 8'hBB, 1'b0);
    idle(3);

    // abort into a new incomplete collection, then complete it
    send(0, 4'd0, 2'b10, 8'h21, 8'h00, 1'b0);
    idle(1);
    expect_ev(0, 1, 0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
    send(0, 4'd2, 2'b10, 8'h42, 8'h00, 1'b0);
    idle(1);
    expect_ev(1, 0, 0, 4'd2, 8'h42, 8'h99, 1'b1, 2'b11);
    send(0, 4'd2, 2'b01, 8'h00, 8'h99, 1'b1);
    idle(3);

    // completing beat on the last WAIT cycle beats the timeout
    send(1, 4'd2, 2'b10, 8'h5A, 8'h00, 1'b0);
    idle(TIMEOUT - 1);
    expect_ev(1, 0, 1, 4'd2, 8'h5A, 8'hA5, 1'b0, 2'b11);
    send(1, 4'd2, 2'b01, 8'h00, 8'hA5, 1'b0);
    idle(3);

    // command with no required operands passes straight through
    expect_ev(1, 0, 0, 4'd14, 8'h00, 8'h00, 1'b0, 2'b00);
    send(0, 4'd14, 2'b00, 8'hC3, 8'h3C, 1'b0);
    idle(3);

    // 6: reset mid-WAIT clears everything at once, no residual events
    send(1, 4'd0, 2'b10, 8'h66, 8'h00, 1'b1);
    idle(2);
    check("t6_busy_before", BUSY, 1'b1);
    RST = 1'b1;
    #2;
    check("t6_rst_busy", BUSY, 1'b0);
    check("t6_rst_opa", ALU_OPA, 8'h00);
    check("t6_rst_cmd", ALU_CMD, 4'd0);
    check("t6_rst_iv", ALU_INP_VALID, 2'b00);
    check("t6_rst_ce", ALU_CE, 1'b0);
    @(negedge CLK); RST = 1'b0;
    idle(2 * TIMEOUT);
    check("t6_busy_after", BUSY, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
